sprite_evaluator: RTL

SPRITE_EVALUATOR -- requirements
Module: sprite_evaluator

---
 rtl/ppu_pkg.sv | 25 ++
 rtl/sprite_range_check.sv | 23 ++
 rtl/sprite_evaluator.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU sprite types, OAM attribute bit positions and evaluator defaults.
package ppu_pkg;

  localparam int unsigned NUM_SPRITES_DEF  = 64;
  localparam int unsigned MAX_PER_LINE_DEF = 8;
  localparam int unsigned SPRITE_H_DEF     = 16;

  localparam int unsigned LINE_W         = 9;
  localparam int unsigned ROW_W          = 4;
  localparam int unsigned ATTR_VFLIP_BIT = 7;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] x;
    logic [7:0] tile;
    logic [7:0] attr;
  } oam_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } eval_state_e;

endpackage

// File: rtl/sprite_range_check.sv
// Vertical range test of one OAM entry against a scanline, with row selection.
module sprite_range_check
  import ppu_pkg::*;
#(
  parameter int unsigned SPRITE_H = SPRITE_H_DEF
) (
  input  logic [7:0]        y_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic              flip_i,
  output logic              hit_o,
  output logic [ROW_W-1:0]  row_o
);

  logic [LINE_W-1:0] diff;

  // Lines above the sprite wrap to large values and fall out of range.
  always_comb begin
    diff  = line_i - {1'b0, y_i};
    hit_o = (diff < LINE_W'(SPRITE_H));
    row_o = flip_i ? (ROW_W'(SPRITE_H - 1) - diff[ROW_W-1:0]) : diff[ROW_W-1:0];
  end

endmodule

// File: rtl/sprite_evaluator.sv
// Per-scanline sprite evaluator: scans OAM in order and loads up to MAX_PER_LINE hits into slots.
// Build option SPRITE_OVERFLOW_EN: keep scanning past a full line and flag the next hit as overflow.
module sprite_evaluator
  import ppu_pkg::*;
#(
  parameter int unsigned NUM_SPRITES  = NUM_SPRITES_DEF,
  parameter int unsigned MAX_PER_LINE = MAX_PER_LINE_DEF,
  parameter int unsigned SPRITE_H     = SPRITE_H_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [8:0]  next_line,
  output logic        oam_rd_en,
  output logic [5:0]  oam_addr,
  input  logic [31:0] oam_data,
  output logic        slot_we,
  output logic [2:0]  slot_idx,
  output logic [7:0]  slot_x,
  output logic [7:0]  slot_tile,
  output logic [7:0]  slot_attr,
  output logic [3:0]  slot_row,
  output logic [3:0]  sprite_count,
  output logic        overflow,
  output logic        done
);

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned SLOT_W = 3;
  localparam int unsigned CNT_W  = 4;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SPRITES - 1);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_PER_LINE);

  eval_state_e       state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              vld_q, vld_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              we_q, we_d;
  logic [SLOT_W-1:0] idx_q, idx_d;
  logic [7:0]        x_q, x_d;
  logic [7:0]        tile_q, tile_d;
  logic [7:0]        attr_q, attr_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              done_q, done_d;

  oam_entry_t       entry;
  logic             hit;
  logic [ROW_W-1:0] hit_row;
  logic             stop_c;

  assign entry = oam_entry_t'(oam_data);

  sprite_range_check #(.SPRITE_H(SPRITE_H)) u_range (
    .y_i    (entry.y),
    .line_i (line_q),
    .flip_i (entry.attr[ATTR_VFLIP_BIT]),
    .hit_o  (hit),
    .row_o  (hit_row)
  );

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    rd_en_d = 1'b0;
    addr_d  = addr_q;
    vld_d   = rd_en_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    we_d    = 1'b0;
    idx_d   = idx_q;
    x_d     = x_q;
    tile_d  = tile_q;
    attr_d  = attr_q;
    row_d   = row_q;
    done_d  = 1'b0;
    stop_c  = 1'b0;

    // Evaluate the entry whose read was issued in the previous cycle.
    if (vld_q && (state_q != ST_IDLE) && hit) begin
      if (count_q < MAX_CNT) begin
        we_d    = 1'b1;
        idx_d   = SLOT_W'(count_q);
        x_d     = entry.x;
        tile_d  = entry.tile;
        attr_d  = entry.attr;
        row_d   = hit_row;
        count_d = count_q + CNT_W'(1);
`ifndef SPRITE_OVERFLOW_EN
        stop_c  = (count_q == (MAX_CNT - CNT_W'(1)));
`endif
      end
`ifdef SPRITE_OVERFLOW_EN
      else begin
        ovf_d  = 1'b1;
        stop_c = 1'b1;
      end
`endif
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_SCAN: begin
        if (stop_c || (addr_q == LAST_ADDR)) begin
          state_d = ST_DRAIN;
        end else begin
          rd_en_d = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        // First DRAIN cycle evaluates the last in-flight entry; done shows in the second.
        if (done_q) state_d = ST_IDLE;
        else        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // line_start from any state restarts the scan and drops in-flight data.
    if (line_start) begin
      state_d = ST_SCAN;
      line_d  = next_line;
      rd_en_d = 1'b1;
      addr_d  = '0;
      vld_d   = 1'b0;
      count_d = '0;
      ovf_d   = 1'b0;
      we_d    = 1'b0;
      idx_d   = idx_q;
      x_d     = x_q;
      tile_d  = tile_q;
      attr_d  = attr_q;
      row_d   = row_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      line_q  <= '0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      x_q     <= '0;
      tile_q  <= '0;
      attr_q  <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      tile_q  <= tile_d;
      attr_q  <= attr_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  assign oam_rd_en    = rd_en_q;
  assign oam_addr     = addr_q;
  assign slot_we      = we_q;
  assign slot_idx     = idx_q;
  assign slot_x       = x_q;
  assign slot_tile    = tile_q;
  assign slot_attr    = attr_q;
  assign slot_row     = row_q;
  assign sprite_count = count_q;
  assign overflow     = ovf_q;
  assign done         = done_q;

endmodule
